// File: rtl/line_buf_scheduler.sv
// line_buf_scheduler
//   Sequences four line buffers for a 3x3 sliding-window filter. Incoming
//   pixels fill the buffers round-robin; once three full lines are held, a
//   line-read pass presents the three lines selected by rd_buf to the window
//   logic, then releases the oldest line for refill.
//
// Ports
//   axi_clk        sole clock, rising edge
//   axi_rst        asynchronous active-low reset
//   i_pixel_valid  incoming pixel present this cycle
//   o_wr_en        one-hot write enable, buffers 0..3
//   o_wr_addr      pixel index within the line being written
//   o_rd_en        read enables, three bits set during a line read
//   o_rd_addr      column read from the three selected lines
//   o_rd_top       buffer holding the top row of the current window
//   o_win_valid    window data valid (o_rd_en delayed one cycle)
//   o_intr         one-cycle pulse when a line has been consumed
//   o_overflow     sticky: pixel dropped because all buffers were full
module line_buf_scheduler #(
  parameter int LINE_WIDTH = 512,
  parameter int NUM_BUFS   = 4
) (
  input  logic                          axi_clk,
  input  logic                          axi_rst,
  input  logic                          i_pixel_valid,
  output logic [NUM_BUFS-1:0]           o_wr_en,
  output logic [$clog2(LINE_WIDTH)-1:0] o_wr_addr,
  output logic [NUM_BUFS-1:0]           o_rd_en,
  output logic [$clog2(LINE_WIDTH)-1:0] o_rd_addr,
  output logic [1:0]                    o_rd_top,
  output logic                          o_win_valid,
  output logic                          o_intr,
  output logic                          o_overflow
);

  localparam int AW = $clog2(LINE_WIDTH);
  localparam int FW = $clog2(4 * LINE_WIDTH + 1);

  localparam logic [AW-1:0] LAST_COL  = AW'(LINE_WIDTH - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(4 * LINE_WIDTH);
  localparam logic [FW-1:0] FILL_READ = FW'(3 * LINE_WIDTH);
  localparam logic [FW-1:0] FILL_LINE = FW'(LINE_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q,     state_d;
  logic [1:0]    wr_buf_q,    wr_buf_d;
  logic [AW-1:0] wr_col_q,    wr_col_d;
  logic [1:0]    rd_buf_q,    rd_buf_d;
  logic [AW-1:0] rd_col_q,    rd_col_d;
  logic [FW-1:0] fill_q,      fill_d;
  logic          win_valid_q, win_valid_d;
  logic          overflow_q,  overflow_d;

  logic                    accept;
  logic [NUM_BUFS-1:0]     wr_onehot;
  logic [NUM_BUFS-1:0]     rd_mask;
  logic [NUM_BUFS-1:0]     rd_en_w;
  logic [2*NUM_BUFS-1:0]   rd_rot;

  always_comb begin
    accept      = i_pixel_valid && (fill_q < FILL_MAX);
    wr_buf_d    = wr_buf_q;
    wr_col_d    = wr_col_q;
    rd_buf_d    = rd_buf_q;
    rd_col_d    = rd_col_q;
    state_d     = state_q;
    overflow_d  = overflow_q | (i_pixel_valid & ~accept);

    if (accept) begin
      if (wr_col_q == LAST_COL) begin
        wr_col_d = '0;
        wr_buf_d = wr_buf_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + AW'(1);
      end
    end

    // Write increment and end-of-line release may land in the same cycle;
    // both are applied.
    fill_d = fill_q + (accept ? FW'(1) : FW'(0));
    if (state_q == DONE) begin
      fill_d = fill_d - FILL_LINE;
    end

    case (state_q)
      // Next-cycle fill is used so the read pass starts the cycle right after
      // the pixel completing the third line is accepted.
      IDLE: if (fill_d >= FILL_READ) state_d = READ;
      READ: begin
        if (rd_col_q == LAST_COL) begin
          rd_col_d = '0;
          state_d  = DONE;
        end else begin
          rd_col_d = rd_col_q + AW'(1);
        end
      end
      DONE: begin
        rd_buf_d = rd_buf_q + 2'd1;
        rd_col_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Three consecutive buffers starting at rd_buf, wrapping modulo 4.
    rd_rot  = {NUM_BUFS'(0), NUM_BUFS'(7)} << rd_buf_q;
    rd_mask = rd_rot[NUM_BUFS-1:0] | rd_rot[2*NUM_BUFS-1:NUM_BUFS];
    rd_en_w = (state_q == READ) ? rd_mask : '0;

    win_valid_d = |rd_en_w;
    wr_onehot   = NUM_BUFS'(1) << wr_buf_q;
  end

  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      state_q     <= IDLE;
      wr_buf_q    <= '0;
      wr_col_q    <= '0;
      rd_buf_q    <= '0;
      rd_col_q    <= '0;
      fill_q      <= '0;
      win_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_buf_q    <= wr_buf_d;
      wr_col_q    <= wr_col_d;
      rd_buf_q    <= rd_buf_d;
      rd_col_q    <= rd_col_d;
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Write enable is combinational from i_pixel_valid, so it is gated by the
  // reset level to stay quiet while reset is held.
  assign o_wr_en     = (accept && axi_rst) ? wr_onehot : '0;
  assign o_wr_addr   = wr_col_q;
  assign o_rd_en     = rd_en_w;
  assign o_rd_addr   = rd_col_q;
  assign o_rd_top    = rd_buf_q;
  assign o_win_valid = win_valid_q;
  assign o_intr      = (state_q == DONE);
  assign o_overflow  = overflow_q;

endmodule
